// File: rtl/gate_net_evaluator.sv
// rtl/gate_net_evaluator.sv - steps a gate network through every input pattern and scores its outputs against a latched truth table
// Optional per-vector fail map enabled with GATE_EVAL_FAIL_MAP_EN.
module gate_net_evaluator #(
    parameter int IN_W          = 2,
    parameter int OUT_W         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [OUT_W*(1<<IN_W)-1:0]         exp_table,
    output logic [IN_W-1:0]                    net_in,
    input  logic [OUT_W-1:0]                   net_out,
    output logic                               busy,
    output logic                               done,
    output logic [IN_W:0]                      match_count,
    output logic [IN_W:0]                      mismatch_count,
    output logic [IN_W+$clog2(OUT_W):0]        bit_err_count,
    output logic                               first_fail_valid,
`ifdef GATE_EVAL_FAIL_MAP_EN
    output logic [(1<<IN_W)-1:0]               fail_map,
`endif
    output logic [IN_W-1:0]                    first_fail_idx
);

    localparam int N    = 1 << IN_W;
    localparam int BE_W = IN_W + $clog2(OUT_W) + 1;
    localparam int PC_W = $clog2(OUT_W) + 1;
    localparam logic [IN_W:0]   CNT_ONE  = (IN_W+1)'(1);
    localparam logic [IN_W-1:0] IDX_LAST = {IN_W{1'b1}};
    localparam logic [IN_W-1:0] IDX_ONE  = IN_W'(1);
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [OUT_W*N-1:0]     table_q, table_d;
    logic [IN_W-1:0]        idx_q, idx_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IN_W:0]          match_q, match_d;
    logic [IN_W:0]          mism_q, mism_d;
    logic [BE_W-1:0]        bit_err_q, bit_err_d;
    logic                   ffv_q, ffv_d;
    logic [IN_W-1:0]        ffi_q, ffi_d;
`ifdef GATE_EVAL_FAIL_MAP_EN
    logic [N-1:0]           fail_map_q, fail_map_d;
`endif

    logic [OUT_W-1:0]       exp_entry;
    logic [OUT_W-1:0]       diff;
    logic [PC_W-1:0]        pop;

    always_comb begin
        exp_entry = table_q[int'(idx_q)*OUT_W +: OUT_W];
        diff      = net_out ^ exp_entry;
        pop       = '0;
        for (int b = 0; b < OUT_W; b++) begin
            pop = pop + PC_W'(diff[b]);
        end
    end

    always_comb begin
        state_d   = state_q;
        table_d   = table_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        mism_d    = mism_q;
        bit_err_d = bit_err_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
`ifdef GATE_EVAL_FAIL_MAP_EN
        fail_map_d = fail_map_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    table_d   = exp_table;
                    idx_d     = '0;
                    cnt_d     = SETTLE_LOAD;
                    busy_d    = 1'b1;
                    match_d   = '0;
                    mism_d    = '0;
                    bit_err_d = '0;
                    ffv_d     = 1'b0;
                    ffi_d     = '0;
`ifdef GATE_EVAL_FAIL_MAP_EN
                    fail_map_d = '0;
`endif
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Counter holds the number of SETTLE cycles still to spend, including this one
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                bit_err_d = bit_err_q + BE_W'(pop);
                if (diff == '0) begin
                    match_d = match_q + CNT_ONE;
                end else begin
                    mism_d = mism_q + CNT_ONE;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
`ifdef GATE_EVAL_FAIL_MAP_EN
                    fail_map_d[idx_q] = 1'b1;
`endif
                end
                if (idx_q == IDX_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            table_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= '0;
            mism_q    <= '0;
            bit_err_q <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
`ifdef GATE_EVAL_FAIL_MAP_EN
            fail_map_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            table_q   <= table_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            mism_q    <= mism_d;
            bit_err_q <= bit_err_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
`ifdef GATE_EVAL_FAIL_MAP_EN
            fail_map_q <= fail_map_d;
`endif
        end
    end

    assign net_in           = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign match_count      = match_q;
    assign mismatch_count   = mism_q;
    assign bit_err_count    = bit_err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
`ifdef GATE_EVAL_FAIL_MAP_EN
    assign fail_map         = fail_map_q;
`endif

endmodule
